// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Registered multi-cycle ALU with valid/ready handshake. Logic,
//            add/sub and shifts finish in one cycle; multiply is radix-2
//            shift-add. Signed restoring divide is built only when the
//            SEQ_ALU_DIV_EN macro is defined.
// Revision : 1.0
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1} state_t;
`endif

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_fast;
  logic [WIDTH-1:0] w_mul_acc;
  logic [SW-1:0]    w_sh;

  assign ready_o   = (r_state == S_IDLE);
  assign w_sh      = data2_i[SW-1:0];
  // Multiplicand shifts left and multiplier right, so bit 0 selects each partial product
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

  always_comb begin
    w_fast = '0;
    case (ALUCtrl_i)
      3'b000:  w_fast = data1_i & data2_i;
      3'b001:  w_fast = data1_i ^ data2_i;
      3'b010:  w_fast = data1_i + data2_i;
      3'b110:  w_fast = data1_i - data2_i;
      3'b111:  w_fast = data1_i << w_sh;
      3'b101:  w_fast = $signed(data1_i) >>> w_sh;
      default: w_fast = '0;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  logic             r_neg;
  logic             r_dz;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_div_res;

  // Most-negative keeps its bit pattern, which is its correct unsigned magnitude
  assign w_mag1    = data1_i[WIDTH-1] ? -data1_i : data1_i;
  assign w_mag2    = data2_i[WIDTH-1] ? -data2_i : data2_i;
  // r_b holds the dividend bits shifting out and the quotient bits shifting in
  assign w_rem_sh  = {r_acc, r_b[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_a};
  assign w_div_res = r_dz ? '1 : (r_neg ? -r_b : r_b);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      Zero_o  <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
      r_neg   <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            case (ALUCtrl_i)
              3'b011: begin
                r_state <= S_MUL;
                r_cnt   <= CW'(WIDTH - 1);
                r_a     <= data1_i;
                r_b     <= data2_i;
                r_acc   <= '0;
              end
`ifdef SEQ_ALU_DIV_EN
              3'b100: begin
                r_state <= S_DIV;
                r_cnt   <= CW'(WIDTH);
                r_a     <= w_mag2;
                r_b     <= w_mag1;
                r_acc   <= '0;
                r_neg   <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
                r_dz    <= (data2_i == '0);
              end
`endif
              default: begin
                data_o  <= w_fast;
                Zero_o  <= (w_fast == '0);
                valid_o <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          if (r_cnt == '0) begin
            data_o  <= w_mul_acc;
            Zero_o  <= (w_mul_acc == '0);
            valid_o <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        S_DIV: begin
          if (r_cnt != '0) begin
            r_acc <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_b   <= {r_b[WIDTH-2:0], ~w_diff[WIDTH]};
            r_cnt <= r_cnt - 1'b1;
          end else begin
            data_o  <= w_div_res;
            Zero_o  <= (w_div_res == '0);
            valid_o <= 1'b1;
            r_state <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Randomized and directed bench for seq_alu at WIDTH 32 and 8,
//            checked against a behavioural result/latency model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  vin = 2'b00;
  logic [2:0]  opc [2];
  logic [63:0] d1 [2];
  logic [63:0] d2 [2];
  logic [1:0]  rdy, vo, zo;
  logic [31:0] dout32;
  logic [7:0]  dout8;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin[0]), .ready_o(rdy[0]),
    .data1_i(d1[0][31:0]), .data2_i(d2[0][31:0]), .ALUCtrl_i(opc[0]),
    .valid_o(vo[0]), .data_o(dout32), .Zero_o(zo[0])
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(vin[1]), .ready_o(rdy[1]),
    .data1_i(d1[1][7:0]), .data2_i(d2[1][7:0]), .ALUCtrl_i(opc[1]),
    .valid_o(vo[1]), .data_o(dout8), .Zero_o(zo[1])
  );

  typedef struct {
    int          id;
    int          due;
    logic [63:0] res;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          busy_end [2];
  logic [63:0] last [2];
  bit          go = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int id);
    return (id == 0) ? 32 : 8;
  endfunction

  function automatic logic [63:0] dv(input int id);
    return (id == 0) ? {32'b0, dout32} : {56'b0, dout8};
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Cycles from the transfer edge to the result-write edge
  function automatic int lat(input int id, input logic [2:0] o);
    if (o == 3'b011) return wid(id);
`ifdef SEQ_ALU_DIV_EN
    if (o == 3'b100) return wid(id) + 1;
`endif
    return 0;
  endfunction

  function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, a, b, r;
    longint      sa, sb;
    int          sh;
    m  = mask_of(w);
    a  = a_in & m;
    b  = b_in & m;
    sa = a[w-1] ? $signed(a | ~m) : $signed(a);
    sb = b[w-1] ? $signed(b | ~m) : $signed(b);
    sh = int'(b & 64'(w - 1));
    case (o)
      3'b000: r = a & b;
      3'b001: r = a ^ b;
      3'b010: r = a + b;
      3'b110: r = a - b;
      3'b111: r = a << sh;
      3'b101: r = 64'(sa >>> sh);
      3'b011: r = 64'(sa * sb);
`ifdef SEQ_ALU_DIV_EN
      3'b100: r = (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(sa / sb);
`else
      3'b100: r = 64'd0;
`endif
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  task automatic chk(input string nm, input int id, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h want=%h cyc=%0d", nm, id, got, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always begin
    int idx;
    @(posedge clk);
    #1;
    if (go) begin
      for (int id = 0; id < 2; id++) begin
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].id == id) idx = i;
        chk("ready", id, 64'(rdy[id]), 64'(cyc >= busy_end[id]));
        if (idx >= 0 && q[idx].due == cyc) begin
          chk("valid_pulse", id, 64'(vo[id]), 64'd1);
          chk("data", id, dv(id), q[idx].res);
          chk("zero", id, 64'(zo[id]), 64'(q[idx].res == 64'd0));
          last[id] = q[idx].res;
          q.delete(idx);
        end else begin
          chk("valid_idle", id, 64'(vo[id]), 64'd0);
          chk("data_hold", id, dv(id), last[id]);
          chk("zero_hold", id, 64'(zo[id]), 64'(last[id] == 64'd0));
        end
      end
    end
  end

  task automatic issue(input int id, input logic [2:0] o, input logic [63:0] a,
                       input logic [63:0] b, output int t);
    int   n;
    exp_t e;
    n = 0;
    t = -1;
    @(negedge clk);
    while (!rdy[id]) begin
      n++;
      if (n > 200) begin
        chk("ready_timeout", id, 64'(rdy[id]), 64'd1);
        return;
      end
      @(negedge clk);
    end
    opc[id] = o;
    d1[id]  = a & mask_of(wid(id));
    d2[id]  = b & mask_of(wid(id));
    vin[id] = 1'b1;
    t       = cyc + 1;
    e.id    = id;
    e.due   = t + lat(id, o);
    e.res   = model(wid(id), o, a, b);
    q.push_back(e);
    busy_end[id] = e.due;
    @(posedge clk);
    #1;
    vin[id] = 1'b0;
    d1[id]  = 64'($urandom);
    d2[id]  = 64'($urandom);
    opc[id] = 3'($urandom);
  endtask

  task automatic expect_out(input string nm, input int id, input int t,
                            input int l, input logic [63:0] v);
    int n;
    n = 0;
    while (!vo[id] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, id, 64'(cyc - t), 64'(l));
    chk(nm, id, dv(id), v);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once
  task automatic reset_now(input bit hold_valid);
    rst = 1'b1;
    q.delete();
    for (int id = 0; id < 2; id++) begin
      busy_end[id] = cyc;
      last[id]     = 64'd0;
    end
    if (hold_valid) begin
      opc[0] = 3'b010;
      d1[0]  = 64'd9;
      d2[0]  = 64'd9;
      vin[0] = 1'b1;
    end
    #1;
    for (int id = 0; id < 2; id++) begin
      chk("rst_ready", id, 64'(rdy[id]), 64'd1);
      chk("rst_valid", id, 64'(vo[id]), 64'd0);
      chk("rst_data", id, dv(id), 64'd0);
      chk("rst_zero", id, 64'(zo[id]), 64'd1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    vin[0] = 1'b0;
    rst    = 1'b0;
  endtask

  function automatic logic [63:0] pick(input int id);
    int w;
    w = wid(id);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return mask_of(w);
      3:       return 64'd1 << (w - 1);
      default: return {32'($urandom), 32'($urandom)} & mask_of(w);
    endcase
  endfunction

  task automatic rand_run(input int id, input int n_ops);
    int t;
    for (int i = 0; i < n_ops; i++) begin
      issue(id, 3'($urandom_range(0, 7)), pick(id), pick(id), t);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    for (int id = 0; id < 2; id++) begin
      opc[id] = 3'b000;
      d1[id] = 64'd0;
      d2[id] = 64'd0;
      busy_end[id] = 0;
      last[id] = 64'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int id = 0; id < 2; id++) begin
      chk("init_ready", id, 64'(rdy[id]), 64'd1);
      chk("init_valid", id, 64'(vo[id]), 64'd0);
      chk("init_data", id, dv(id), 64'd0);
      chk("init_zero", id, 64'(zo[id]), 64'd1);
    end
    go = 1'b1;

    chk("pin_add", 0, model(32, 3'b010, 64'h7FFF_FFFF, 64'd1), 64'h8000_0000);
    chk("pin_sra", 0, model(32, 3'b101, 64'h8000_0000, 64'h21), 64'hC000_0000);
    chk("pin_mul", 0, model(32, 3'b011, 64'hFFFF_FFFD, 64'd7), 64'hFFFF_FFEB);
    chk("pin_sll8", 1, model(8, 3'b111, 64'd1, 64'h0B), 64'h08);

    // Back-to-back fast ops; the compare process sees one pulse per cycle
    issue(0, 3'b010, 64'h7FFF_FFFF, 64'd1, t);
    issue(0, 3'b110, 64'd5, 64'd5, t);
    issue(0, 3'b101, 64'h8000_0000, 64'h21, t);
    issue(0, 3'b111, 64'd1, 64'd31, t);
    expect_out("sll31", 0, t, 0, 64'h8000_0000);

    @(posedge clk);
    #3;
    reset_now(1'b1);

    // MUL with a competing request held during the busy period
    issue(0, 3'b011, 64'hFFFF_FFFD, 64'd7, t);
    vin[0] = 1'b1;
    opc[0] = 3'b010;
    repeat (20) begin
      d1[0] = 64'($urandom);
      d2[0] = 64'($urandom);
      @(negedge clk);
    end
    vin[0] = 1'b0;
    expect_out("mul_neg3x7", 0, t, 32, 64'hFFFF_FFEB);

`ifdef SEQ_ALU_DIV_EN
    issue(0, 3'b100, 64'hFFFF_FFF9, 64'd2, t);
    expect_out("div_neg7by2", 0, t, 33, 64'hFFFF_FFFD);
    issue(0, 3'b100, 64'd5, 64'd0, t);
    expect_out("div_by0", 0, t, 33, 64'hFFFF_FFFF);
    issue(0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, t);
    expect_out("div_ovf", 0, t, 33, 64'h8000_0000);
`else
    issue(0, 3'b100, 64'd5, 64'd3, t);
    expect_out("div_off", 0, t, 0, 64'd0);
    chk("div_off_zero", 0, 64'(zo[0]), 64'd1);
`endif

    // Reset lands mid-multiply, just after edge T+10
    issue(0, 3'b011, 64'd123, 64'd456, t);
    n = 0;
    while (cyc != t + 10 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    #2;
    reset_now(1'b0);
    repeat (3) @(negedge clk);
    issue(0, 3'b010, 64'd2, 64'd3, t);
    expect_out("add_after_rst", 0, t, 0, 64'd5);

    issue(1, 3'b011, 64'h10, 64'h10, t);
    expect_out("mul8", 1, t, 8, 64'h00);
    chk("mul8_zero", 1, 64'(zo[1]), 64'd1);
    issue(1, 3'b111, 64'd1, 64'h0B, t);
    expect_out("sll8", 1, t, 0, 64'h08);

    fork
      rand_run(0, 250);
      rand_run(1, 300);
    join

    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 0, 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the single-cycle CPU's combinational ALU. It registers its result and uses a valid/ready handshake. Logic, add/sub and shift operations complete in one cycle at full throughput. Multiply, and optionally divide, run iteratively over several cycles. It sits between the operand muxes and the writeback stage of the multi-cycle/pipelined core, and the hazard unit stalls on `ready_o`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; must be a power of two, 8..64.

Ports:
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `valid_i`  in  1  an operation is presented.
- `ready_o`  out  1  the block can accept; high exactly when the FSM is in IDLE.
- `data1_i`  in  WIDTH  operand A, signed two's complement.
- `data2_i`  in  WIDTH  operand B, signed two's complement.
- `ALUCtrl_i`  in  3  operation code.
- `valid_o`  out  1  one-cycle pulse; a new result is on `data_o`.
- `data_o`  out  WIDTH  registered result; held until the next result.
- `Zero_o`  out  1  registered; high when `data_o == 0`, updated together with `data_o`.

## Operation
- A transfer occurs on a rising edge with `valid_i && ready_o && !rst_i`.
- Operands and op code are captured at the transfer. Input changes after it have no effect.
- Op codes:
  - 000 AND, 001 XOR, 010 ADD, 110 SUB: low WIDTH bits, wrap on overflow.
  - 111 SLL, 101 SRA: shift amount is `data2_i[log2(WIDTH)-1:0]`; the upper bits are ignored. SRA is arithmetic.
  - 011 MUL: low WIDTH bits of the product, identical for signed and unsigned. Radix-2 shift-add, one partial product per cycle.
  - 100 DIV: see Configuration.
- FSM states are IDLE, MUL and DIV.
  - Fast ops (all except 011/100): result written at the transfer edge; FSM stays in IDLE.
  - MUL: IDLE→MUL at transfer. A down-counter is loaded with WIDTH-1 and decrements each edge. When the counter reaches 0, the result is written and the FSM returns to IDLE.
  - DIV: IDLE→DIV. Operands are converted to magnitudes, WIDTH restoring iterations run, then a final sign-correction edge writes the result and returns to IDLE.
- `valid_o` is high for exactly the one cycle following the result-write edge.
- `valid_i` while `ready_o` is low is ignored. The upstream stage must hold its request.
- Reset mid-operation aborts the operation. Nothing is written and no `valid_o` pulse occurs.
- Reset values:
  - FSM state IDLE, so `ready_o`=1.
  - `valid_o`=0.
  - `data_o`=0.
  - `Zero_o`=1.
  - Counter = 0.
- While `rst_i` is high, no transfer is taken regardless of `ready_o`.

## Timing
- Counts are from the transfer edge T.
- Fast ops: result written at T; `valid_o` high during the cycle after T. Throughput is 1 op/cycle back-to-back.
- MUL: result written at edge T+WIDTH. `ready_o` is low from T until that edge, then high in the same cycle `valid_o` is high. A new op may transfer on the next edge (T+WIDTH+1).
- DIV (macro on): result written at edge T+WIDTH+1, with `ready_o`/`valid_o` behaving as for MUL.
- There is no combinational path from the inputs to `data_o`, `Zero_o` or `valid_o`.

## Configuration
- Macro: `SEQ_ALU_DIV_EN`.
- Defined:
  - Op 100 is signed divide, quotient truncated toward zero.
  - Divide by zero gives all-ones (-1).
  - Most-negative ÷ -1 gives most-negative.
  - Divider datapath and DIV state are present.
- Undefined:
  - Op 100 is treated as a fast op with result 0 (`Zero_o`=1).
  - The DIV state and divider logic are absent.

## Test plan
- Reset: assert `rst_i` asynchronously mid-cycle. Outputs go immediately to `ready_o`=1, `valid_o`=0, `data_o`=0, `Zero_o`=1. A pending `valid_i` during reset causes no transfer.
- Back-to-back fast ops, WIDTH=32, one per cycle:
  - ADD 7FFFFFFF+1 → 80000000.
  - SUB 5-5 → 0 with `Zero_o`=1.
  - SRA 80000000 by 0x21 → C0000000 (shift amount 1).
  - SLL 1 by 31 → 80000000.
  - Expect a `valid_o` pulse on each consecutive cycle.
- MUL, WIDTH=32:
  - -3×7 → FFFFFFEB with `valid_o` exactly 32 edges after the transfer.
  - `ready_o` low throughout the 32 edges.
  - `valid_i` with different operands asserted during the busy period is ignored.
- DIV (macro on):
  - -7÷2 → FFFFFFFD at edge T+33.
  - 5÷0 → FFFFFFFF.
  - 80000000÷FFFFFFFF → 80000000.
  - Macro off: op 100 → 0 in one cycle.
- Reset during MUL at edge T+10:
  - No `valid_o` pulse; `data_o` reads 0.
  - A fresh ADD 2+3 after reset releases yields 5 one cycle later.
- Parameter sweep, WIDTH=8: MUL 0x10×0x10 → 0x00 with `Zero_o`=1 after 8 edges; SLL amount taken from `data2_i[2:0]`.
